// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU and its command sequencer: operation
// encodings, sequencer states and the data width.
package alu_defs;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ALU_ADI = 3'b000,
      ALU_ADD = 3'b001,
      ALU_SUB = 3'b010,
      ALU_AND = 3'b011,
      ALU_ORR = 3'b100,
      ALU_XOR = 3'b101,
      ALU_LSL = 3'b110,
      ALU_LSR = 3'b111
   } alu_func_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } seq_state_e;

   function automatic logic is_shift(input logic [2:0] func);
      return (func == ALU_LSL) || (func == ALU_LSR);
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU. Shifts move B by exactly one bit; the carry flag
// is the 9th bit for ADI/ADD/SUB (borrow for SUB) and zero otherwise.
module alu
   import alu_defs::*;
(
   input  logic [2:0]        func_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] res_o,
   output logic              fz_o,
   output logic              fc_o
);

   alu_func_e   func;
   logic [DATA_W:0] sum;

   assign func = alu_func_e'(func_i);

   // A single 9-bit result carries both the data and the carry/borrow bit
   always_comb begin
      sum = '0;
      case (func)
         ALU_ADI, ALU_ADD: sum = {1'b0, a_i} + {1'b0, b_i};
         ALU_SUB:          sum = {1'b0, a_i} - {1'b0, b_i};
         ALU_AND:          sum = {1'b0, a_i & b_i};
         ALU_ORR:          sum = {1'b0, a_i | b_i};
         ALU_XOR:          sum = {1'b0, a_i ^ b_i};
         ALU_LSL:          sum = {1'b0, b_i[DATA_W-2:0], 1'b0};
         ALU_LSR:          sum = {2'b00, b_i[DATA_W-1:1]};
         default:          sum = '0;
      endcase
   end

   assign res_o = sum[DATA_W-1:0];
   assign fc_o  = sum[DATA_W];
   assign fz_o  = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle sequencer in front of the ALU: latches one command, iterates
// single-bit shifts, and holds the registered result on a valid/ready channel.
module alu_seq
   import alu_defs::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [2:0]  cmd_func_i,
   input  logic [7:0]  cmd_a_imm_i,
   input  logic [3:0]  cmd_a_mem_i,
   input  logic [7:0]  cmd_b_i,
   input  logic [2:0]  cmd_cnt_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [7:0]  res_data_o,
   output logic        res_fz_o,
   output logic        res_fc_o,
   output logic        busy_o
);

   seq_state_e  state_q, state_d;
   logic [2:0]  func_q, func_d;
   logic [7:0]  a_imm_q, a_imm_d;
   logic [3:0]  a_mem_q, a_mem_d;
   logic [7:0]  b_q, b_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  res_data_q, res_data_d;
   logic        res_fz_q, res_fz_d;
   logic        res_fc_q, res_fc_d;

   logic [7:0]  alu_a;
   logic [7:0]  alu_res;
   logic        alu_fz;
   logic        alu_fc;
   logic        cmd_accept;

   // The ALU only ever sees latched operands, never the command ports
   assign alu_a = (func_q == ALU_ADI) ? a_imm_q : {4'b0000, a_mem_q};

   alu u_alu (
      .func_i (func_q),
      .a_i    (alu_a),
      .b_i    (b_q),
      .res_o  (alu_res),
      .fz_o   (alu_fz),
      .fc_o   (alu_fc)
   );

   assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
   assign cmd_accept  = cmd_valid_i && cmd_ready_o;
   assign res_valid_o = (state_q == S_DONE);
   assign busy_o      = (state_q != S_IDLE);
   assign res_data_o  = res_data_q;
   assign res_fz_o    = res_fz_q;
   assign res_fc_o    = res_fc_q;

   always_comb begin
      state_d    = state_q;
      func_d     = func_q;
      a_imm_d    = a_imm_q;
      a_mem_d    = a_mem_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      res_data_d = res_data_q;
      res_fz_d   = res_fz_q;
      res_fc_d   = res_fc_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_accept) begin
               func_d  = cmd_func_i;
               a_imm_d = cmd_a_imm_i;
               a_mem_d = cmd_a_mem_i;
               b_d     = cmd_b_i;
               cnt_d   = is_shift(cmd_func_i) ? cmd_cnt_i : 3'd0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            // Shifts feed the one-bit result back into B until the count runs out
            if (is_shift(func_q)) begin
               b_d = alu_res;
            end
            if (is_shift(func_q) && (cnt_q != 3'd0)) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               res_data_d = alu_res;
               res_fz_d   = alu_fz;
               res_fc_d   = alu_fc;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         func_q     <= 3'd0;
         a_imm_q    <= 8'd0;
         a_mem_q    <= 4'd0;
         b_q        <= 8'd0;
         cnt_q      <= 3'd0;
         res_data_q <= 8'd0;
         res_fz_q   <= 1'b0;
         res_fc_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         func_q     <= func_d;
         a_imm_q    <= a_imm_d;
         a_mem_q    <= a_mem_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         res_data_q <= res_data_d;
         res_fz_q   <= res_fz_d;
         res_fc_q   <= res_fc_d;
      end
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer in front of the 8-bit ALU. Accepts one ALU command at a time over a valid/ready handshake and latches the operands. Drives the ALU for one cycle, or for 1–8 cycles on shift operations (iterated single-bit shifts). Presents the registered result and Z/C flags on a valid/ready output channel. It sits between the CPU decode stage and the ALU, and is the only driver of the ALU's inputs.

## Interface
Parameters:
- none; widths are fixed (8-bit data, 4-bit memory operand, 3-bit func, 3-bit shift count).

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  sequencer can accept (IDLE and not in reset)
- cmd_func_i  in  3  ALU op: 000 ADI, 001 ADD, 010 SUB, 011 AND, 100 ORR, 101 XOR, 110 LSL, 111 LSR
- cmd_a_imm_i  in  8  immediate A operand (used by ADI only)
- cmd_a_mem_i  in  4  memory A operand, zero-extended (all non-ADI ops)
- cmd_b_i  in  8  B operand
- cmd_cnt_i  in  3  shift count minus one (LSL/LSR perform cnt+1 shifts); ignored otherwise
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer takes result
- res_data_o  out  8  result
- res_fz_o  out  1  zero flag of result
- res_fc_o  out  1  carry/borrow flag (9th bit for ADI/ADD/SUB, else 0)
- busy_o  out  1  high in EXEC or DONE

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready_o=1.
  - On cmd_valid_i & cmd_ready_o: latch func, a_imm, a_mem, b, cnt; load iteration counter with cnt (shift ops) or 0 (others); go to EXEC.
- EXEC: ALU inputs come only from the latched registers, never from cmd_* ports.
  - Non-shift op: capture ALU result/fz/fc into result registers; go to DONE.
  - Shift op: each cycle, write the ALU result back into the latched B register.
  - Shift op, counter ≠ 0: decrement the counter and stay in EXEC.
  - Shift op, counter = 0: capture result/flags and go to DONE.
  - fc is 0 for shifts; fz is evaluated on the final value.
- DONE: res_valid_o=1.
  - On res_ready_i: go to IDLE.
  - res_data_o/fz/fc hold stable while waiting and persist after the handshake until the next capture.
- Arithmetic: ADI/ADD/SUB compute a 9-bit {fc,result}; SUB sets fc=1 on borrow (a<b).
- A operand: imm for ADI, {4'b0,a_mem} otherwise.
- No command overlap: cmd_ready_o=0 in EXEC and DONE, including the DONE cycle where res_ready_i is high. A new command is accepted no earlier than the cycle after return to IDLE.
- Reset (any state, including mid-shift): state←IDLE; counter, latched operands and result registers←0; pending result is discarded.
- Reset values: res_valid_o=0, res_data_o=0, res_fz_o=0, res_fc_o=0, busy_o=0.
- cmd_ready_o is forced to 0 while rst_i=1, and is 1 from the first cycle after rst_i deasserts.

## Timing
- Accept on edge E0. EXEC lasts N cycles: N=1 for non-shift ops, N=cnt+1 for shifts.
- res_valid_o rises after edge E0+N.
- Minimum command-to-command interval is N+2 cycles: N in EXEC, 1 in DONE with res_ready_i high, 1 in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from cmd_* or res_ready_i to any output.
- Simultaneous cmd_valid_i during DONE is ignored; the command must be held until cmd_ready_o.

## Structure
- Shared header/package alu_defs: func encodings (ALU_ADI…ALU_LSR), state encodings (S_IDLE, S_EXEC, S_DONE), data width constant 8.
- The existing alu module is used unchanged; alu is the one natural sub-module.
- Per this block's spec, alu sets fc=0 for AND/ORR/XOR/LSL/LSR and fz from the 8-bit result; alu_seq adds no extra flag logic.

## Test plan
- ADD a_mem=0xF, b=0xF1 → res_data=0x00, fz=1, fc=1; res_valid 1 cycle after accept.
- SUB a_mem=0x3, b=0x05 → 0xFE, fz=0, fc=1. ADI imm=0x12, b=0x34 → 0x46, fz=0, fc=0.
- LSL b=0x01, cnt=3 → 4 EXEC cycles, result 0x10, fc=0. LSR b=0xFF, cnt=7 → 8 cycles, 0x00, fz=1.
- Backpressure: hold res_ready_i=0 for 5 cycles after XOR a_mem=0xA, b=0x0F.
  - res_valid_o, res_data_o=0x05 and flags stay stable; cmd_ready_o=0 throughout.
  - After the handshake, IDLE for one cycle, then the next command is accepted.
- Reset asserted on the 3rd EXEC cycle of LSL cnt=7.
  - All outputs read 0 the next cycle; no res_valid_o pulse.
  - After rst_i deasserts, AND a_mem=0x6, b=0x3 → 0x02.
- cmd_valid_i held high with changing operands during EXEC → the result reflects only the operands latched at accept.
